cdb_reservation_station: RTL
============================

# cdb_reservation_station

Receiving end of the common data bus: a bank of up to four reservation-station entries for one functional unit (ADD/SUB or MUL/DIV). It accepts issued instructions, snoops every CDB broadcast to capture pending operands by tag, dispatches ready entries to its functional unit, and frees an entry when the CDB carries that entry's own result. It sits between the issue logic and the functional unit; the CDB arbiter drives its `cdbIn`.

## Interface
- `ENTRIES`, 4: number of entries, 1..4 (2-bit label).
- `UNIT_ID`, 0: value of CDB bit [21] that identifies this bank (0 = ADD/SUB, 1 = MUL/DIV).
- `Clock`  in  1  single clock, rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `cdbIn`  in  23  CDB word: [22] valid, [21] unit, [20:19] station label, [18:16] destination register, [15:0] data. Tag = {[21],[20:19]}.
- `issue_valid` / `issue_ready`  in/out  1  issue handshake.
- `issue_op`  in  2  operation code, passed through unchanged.
- `issue_dest`  in  3  destination register R0..R7.
- `issue_vj`, `issue_vk`  in  16  operand values, used when not pending.
- `issue_qj`, `issue_qk`  in  3  producer tags.
- `issue_qj_busy`, `issue_qk_busy`  in  1  1 = the operand is pending on its tag.
- `issue_label`  out  2  entry index allocated on the current issue.
- `disp_valid` / `disp_ready`  out/in  1  dispatch handshake to the functional unit.
- `disp_op`  out  2; `disp_vj`, `disp_vk`  out  16; `disp_dest`  out  3; `disp_label`  out  2.
- `busy`  out  ENTRIES  per-entry occupied flag (not FREE).

## Operation
- Each entry has state FREE, WAIT, READY, or EXEC, plus op, dest, Vj, Vk, Qj, Qk, and the Jbusy/Kbusy flags.
- **Issue.** `issue_ready` = any entry FREE. `issue_label` = lowest-index FREE entry. On `issue_valid & issue_ready`, that entry loads the issue fields.
  - The entry enters READY if neither operand is still pending; otherwise it enters WAIT.
  - Same-cycle forwarding: if `cdbIn[22]` is set and the CDB tag equals `issue_qj` (resp. `issue_qk`) with that busy flag set, the entry takes the CDB data, and that operand counts as not pending.
- **Snoop.** Every cycle with `cdbIn[22]=1`, each WAIT entry whose Jbusy is set and whose Qj equals the CDB tag loads Vj = `cdbIn[15:0]` and clears Jbusy. The same rule applies to K.
  - A single broadcast may resolve both operands of an entry.
  - An entry goes WAIT→READY on the edge where its last pending operand clears.
- **Dispatch.** `disp_valid` = any READY entry. The selected entry is the lowest-index READY entry, and its fields drive the `disp_*` outputs combinationally. On `disp_valid & disp_ready`, that entry goes READY→EXEC.
- **Completion.** When `cdbIn[22]=1`, `cdbIn[21]=UNIT_ID`, and `cdbIn[20:19]` is an entry in EXEC, that entry goes to FREE and clears its fields.
  - A matching broadcast for an entry not in EXEC is ignored. Flag it with a simulation assertion.
- Broadcasts with `cdbIn[22]=0` are ignored completely.
- The CDB destination field [18:16] is not used for matching; tags alone decide matches.

## Timing
- Reset (`Resetn`=0, asynchronous): all entries FREE, all fields zero. Outputs: `busy`=0, `issue_ready`=1, `issue_label`=0, `disp_valid`=0, all `disp_*`=0.
- Asserting reset mid-operation discards every entry; any in-flight results for them are then ignored.
- Issue with no pending operand: entry READY and `disp_valid`=1 one cycle after the issue edge.
- CDB capture: dependent entry READY one cycle after the broadcast edge.
- A freed entry is FREE on the next cycle. It is reissuable in that cycle, not in the cycle of the broadcast.
- The following events are legal together on one edge and must all take effect independently: issue, snoop, dispatch, and completion on different entries.
- `disp_*` are held stable while `disp_valid & !disp_ready`, unless a lower-index entry becomes READY. Priority by index is intentional.

## Test plan
- **Reset then issue, no dependencies.**
  - Stimulus: issue op=0, Vj=5, Vk=7, dest=R2.
  - Required: next cycle `disp_valid`=1, `disp_vj`=5, `disp_vk`=7, `disp_label`=0, `busy`=0001.
- **Dependency capture.**
  - Stimulus: issue with Qj=3'b101 busy, Vk=4; two cycles later CDB {valid=1, unit=1, label=01, data=0x0010}.
  - Required: `disp_valid` rises the next cycle with Vj=0x0010, Vk=4.
- **Same-cycle forward.**
  - Stimulus: issue with Qk=3'b100 busy in the same cycle as a matching CDB broadcast carrying 0x00FF.
  - Required: entry READY the next cycle with Vk=0x00FF.
- **Full bank.**
  - Stimulus: 4 issues with no dispatch.
  - Required: `issue_ready`=0 and `busy`=1111.
  - Then: dispatch entry 2 and broadcast {UNIT_ID, label 2}. Required: next cycle `busy`=1011, `issue_ready`=1, `issue_label`=2.
- **Backpressure and priority.**
  - Stimulus: entries 1 and 3 READY, `disp_ready`=0 for 3 cycles.
  - Required: `disp_label`=1, stable. Then `disp_ready`=1 for 2 cycles: entry 1 then entry 3 go to EXEC.
- **Async reset mid-flight.**
  - Stimulus: drop `Resetn` between clock edges while 3 entries are busy.
  - Required: `busy`=0 and `disp_valid`=0 immediately, before the next edge. A later completion broadcast has no effect.

Source files
------------

// File: rtl/cdb_reservation_station.sv
// cdb_reservation_station: reservation-station bank that snoops the CDB for operands and its own completions
module cdb_reservation_station #(
    parameter int   ENTRIES = 4,
    parameter logic UNIT_ID = 1'b0
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic [22:0]        cdbIn,
    input  logic               issue_valid,
    output logic               issue_ready,
    input  logic [1:0]         issue_op,
    input  logic [2:0]         issue_dest,
    input  logic [15:0]        issue_vj,
    input  logic [15:0]        issue_vk,
    input  logic [2:0]         issue_qj,
    input  logic [2:0]         issue_qk,
    input  logic               issue_qj_busy,
    input  logic               issue_qk_busy,
    output logic [1:0]         issue_label,
    output logic               disp_valid,
    input  logic               disp_ready,
    output logic [1:0]         disp_op,
    output logic [15:0]        disp_vj,
    output logic [15:0]        disp_vk,
    output logic [2:0]         disp_dest,
    output logic [1:0]         disp_label,
    output logic [ENTRIES-1:0] busy
);
    typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY, S_EXEC} state_t;
    state_t      state [ENTRIES];
    logic [1:0]  op    [ENTRIES];
    logic [2:0]  dest  [ENTRIES];
    logic [2:0]  qj    [ENTRIES];
    logic [2:0]  qk    [ENTRIES];
    logic [15:0] vj    [ENTRIES];
    logic [15:0] vk    [ENTRIES];
    logic        jbusy [ENTRIES];
    logic        kbusy [ENTRIES];
    logic               cdb_valid, fwd_j, fwd_k, pend_j, pend_k, issue_fire, disp_fire, stray, unused_dest;
    logic [2:0]         cdb_tag;
    logic [15:0]        cdb_data;
    logic [ENTRIES-1:0] snoop_j, snoop_k, done;
    assign cdb_valid   = cdbIn[22];
    assign cdb_tag     = cdbIn[21:19];
    assign cdb_data    = cdbIn[15:0];
    assign unused_dest = ^cdbIn[18:16];
    assign fwd_j       = cdb_valid && issue_qj_busy && cdb_tag == issue_qj;
    assign fwd_k       = cdb_valid && issue_qk_busy && cdb_tag == issue_qk;
    assign pend_j      = issue_qj_busy && !fwd_j;
    assign pend_k      = issue_qk_busy && !fwd_k;
    assign issue_fire  = issue_valid && issue_ready;
    assign disp_fire   = disp_valid && disp_ready;
    // Scanning high to low leaves the lowest-index FREE/READY entry selected.
    always_comb begin
        issue_ready = 1'b0;
        issue_label = '0;
        disp_valid  = 1'b0;
        disp_label  = '0;
        disp_op     = '0;
        disp_dest   = '0;
        disp_vj     = '0;
        disp_vk     = '0;
        busy        = '0;
        snoop_j     = '0;
        snoop_k     = '0;
        done        = '0;
        stray       = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            busy[i]    = state[i] != S_FREE;
            snoop_j[i] = cdb_valid && jbusy[i] && qj[i] == cdb_tag;
            snoop_k[i] = cdb_valid && kbusy[i] && qk[i] == cdb_tag;
            done[i]    = cdb_valid && cdbIn[21] == UNIT_ID && cdbIn[20:19] == 2'(i);
            stray      = stray || (done[i] && state[i] != S_EXEC);
            if (state[i] == S_FREE) begin
                issue_ready = 1'b1;
                issue_label = 2'(i);
            end
            if (state[i] == S_READY) begin
                disp_valid = 1'b1;
                disp_label = 2'(i);
                disp_op    = op[i];
                disp_dest  = dest[i];
                disp_vj    = vj[i];
                disp_vk    = vk[i];
            end
        end
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state[i] <= S_FREE;
                op[i]    <= '0;
                dest[i]  <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
                jbusy[i] <= 1'b0;
                kbusy[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (issue_fire && issue_label == 2'(i)) begin
                    state[i] <= (pend_j || pend_k) ? S_WAIT : S_READY;
                    op[i]    <= issue_op;
                    dest[i]  <= issue_dest;
                    qj[i]    <= issue_qj;
                    qk[i]    <= issue_qk;
                    vj[i]    <= fwd_j ? cdb_data : issue_vj;
                    vk[i]    <= fwd_k ? cdb_data : issue_vk;
                    jbusy[i] <= pend_j;
                    kbusy[i] <= pend_k;
                end else if (state[i] == S_WAIT) begin
                    if (snoop_j[i]) begin
                        vj[i]    <= cdb_data;
                        jbusy[i] <= 1'b0;
                    end
                    if (snoop_k[i]) begin
                        vk[i]    <= cdb_data;
                        kbusy[i] <= 1'b0;
                    end
                    state[i] <= ((jbusy[i] && !snoop_j[i]) || (kbusy[i] && !snoop_k[i])) ? S_WAIT : S_READY;
                end else if (state[i] == S_READY && disp_fire && disp_label == 2'(i)) begin
                    state[i] <= S_EXEC;
                end else if (state[i] == S_EXEC && done[i]) begin
                    state[i] <= S_FREE;
                    op[i]    <= '0;
                    dest[i]  <= '0;
                    qj[i]    <= '0;
                    qk[i]    <= '0;
                    vj[i]    <= '0;
                    vk[i]    <= '0;
                    jbusy[i] <= 1'b0;
                    kbusy[i] <= 1'b0;
                end
            end
        end
    end
    assert property (@(posedge Clock) disable iff (!Resetn) !stray)
        else $warning("completion broadcast for entry %0d which is not executing", cdbIn[20:19]);
endmodule
